// File: rtl/regfile_arbiter_if.sv
// Requester-side bundle for the shared register file:
// request handshake plus held read-response channel.
interface regfile_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic              write;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data_a;
  logic [DATA_W-1:0] rsp_data_b;

  modport master (
    output valid, write, addr_a, addr_b, wdata,
    output rsp_ready,
    input  ready, rsp_valid, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  valid, write, addr_a, addr_b, wdata,
    input  rsp_ready,
    output ready, rsp_valid, rsp_data_a, rsp_data_b
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter serialising two requesters onto
// one 2-read/1-write register file, one op per grant.
module regfile_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  regfile_arbiter_if.slave  req0,
  regfile_arbiter_if.slave  req1,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b
);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESP_HOLD
  } state_t;

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic              owner;
  logic [ADDR_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] rsp0_a, rsp0_b;
  logic [DATA_W-1:0] rsp1_a, rsp1_b;

  logic              grant;
  logic              gsel;
  logic              g_write;
  logic [ADDR_W-1:0] g_a, g_b;
  logic [DATA_W-1:0] g_wd;
  logic              rsp_take;

  // Grants are suppressed while reset is held so ready stays low.
  assign grant = (state == IDLE) && nReset
               && (req0.valid || req1.valid);
  assign gsel  = (req0.valid && req1.valid) ? rr_ptr
                                            : req1.valid;

  assign g_write = gsel ? req1.write  : req0.write;
  assign g_a     = gsel ? req1.addr_a : req0.addr_a;
  assign g_b     = gsel ? req1.addr_b : req0.addr_b;
  assign g_wd    = gsel ? req1.wdata  : req0.wdata;

  assign req0.ready = grant && !gsel;
  assign req1.ready = grant && gsel;

  assign req0.rsp_valid  = (state == RESP_HOLD) && !owner;
  assign req1.rsp_valid  = (state == RESP_HOLD) && owner;
  assign req0.rsp_data_a = rsp0_a;
  assign req0.rsp_data_b = rsp0_b;
  assign req1.rsp_data_a = rsp1_a;
  assign req1.rsp_data_b = rsp1_b;

  assign rsp_take = (state == RESP_HOLD)
                  && (owner ? req1.rsp_ready : req0.rsp_ready);

  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_addr_a = '0;
    rf_addr_b = '0;
    rf_wdata  = '0;
    unique case (state)
      IDLE: begin
        if (grant && g_write) begin
          rf_we     = 1'b1;
          rf_addr_a = g_a;
          rf_wdata  = g_wd;
        end else if (grant) begin
          rf_addr_a = g_a;
          rf_addr_b = g_b;
          state_nxt = READ_WAIT;
        end
      end
      READ_WAIT: begin
        rf_addr_a = rd_a;
        rf_addr_b = rd_b;
        state_nxt = RESP_HOLD;
      end
      RESP_HOLD: begin
        if (rsp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      owner  <= 1'b0;
      rd_a   <= '0;
      rd_b   <= '0;
      rsp0_a <= '0;
      rsp0_b <= '0;
      rsp1_a <= '0;
      rsp1_b <= '0;
    end else begin
      state <= state_nxt;
      if (grant) rr_ptr <= ~gsel;
      if (grant && !g_write) begin
        owner <= gsel;
        rd_a  <= g_a;
        rd_b  <= g_b;
      end
      if (state == READ_WAIT) begin
        if (owner) begin
          rsp1_a <= rf_rdata_a;
          rsp1_b <= rf_rdata_b;
        end else begin
          rsp0_a <= rf_rdata_a;
          rsp0_b <= rf_rdata_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus
// random traffic against a transaction-level model.
module tb_regfile_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic [AW-1:0] rf_addr_a, rf_addr_b;
  logic [DW-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;
  logic          rf_we;

  regfile_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r0 ();
  regfile_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r1 ();

  regfile_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .req0       (r0),
    .req1       (r1),
    .rf_addr_a  (rf_addr_a),
    .rf_addr_b  (rf_addr_b),
    .rf_wdata   (rf_wdata),
    .rf_we      (rf_we),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b)
  );

  always #5 Clock = ~Clock;

  // Register file: synchronous write, registered reads.
  logic [DW-1:0] rf_mem [64];
  always @(posedge Clock) begin
    if (rf_we) rf_mem[rf_addr_a] <= rf_wdata;
    rf_rdata_a <= rf_mem[rf_addr_a];
    rf_rdata_b <= rf_mem[rf_addr_b];
  end

  logic [DW-1:0] ref_mem [64];
  int tests = 0;
  int fails = 0;
  bit rr_m = 1'b0;

  task automatic set_req(input int who, input bit v,
                         input bit w, input logic [AW-1:0] a,
                         input logic [AW-1:0] b,
                         input logic [DW-1:0] d);
    if (who == 0) begin
      r0.valid = v; r0.write = w;
      r0.addr_a = a; r0.addr_b = b; r0.wdata = d;
    end else begin
      r1.valid = v; r1.write = w;
      r1.addr_a = a; r1.addr_b = b; r1.wdata = d;
    end
  endtask

  task automatic idle_all();
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    r0.rsp_ready = 1'b0;
    r1.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    nReset = 1'b0;
    idle_all();
    @(negedge Clock);
    nReset = 1'b1;
    rr_m = 1'b0;
  endtask

  function automatic logic [96:0] all_outs();
    return {r0.ready, r1.ready, r0.rsp_valid, r1.rsp_valid,
            rf_we, rf_addr_a, rf_addr_b, rf_wdata,
            r0.rsp_data_a, r0.rsp_data_b,
            r1.rsp_data_a, r1.rsp_data_b};
  endfunction

  task automatic test_reset();
    set_req(0, 1, 1, 6'd3, 6'd4, 16'h5555);
    set_req(1, 1, 0, 6'd7, 6'd8, 16'h6666);
    r0.rsp_ready = 1'b1;
    r1.rsp_ready = 1'b1;
    #2;
    tests++;
    if (all_outs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    @(negedge Clock);
    idle_all();
    nReset = 1'b1;
    #1;
    tests++;
    if ({rf_we, r0.rsp_valid, r1.rsp_valid} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release got=%b want=000",
               {rf_we, r0.rsp_valid, r1.rsp_valid});
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] eb;
    @(negedge Clock);
    set_req(0, 1, 1, 6'd5, 6'd0, 16'hBEEF);
    #1;
    tests++;
    if ({r0.ready, r1.ready, rf_we, rf_addr_a, rf_wdata}
        !== {1'b1, 1'b0, 1'b1, 6'd5, 16'hBEEF}) begin
      fails++;
      $display("FAIL wr_grant got=%b%b%b a=%0d d=%h want=101 a=5 d=beef",
               r0.ready, r1.ready, rf_we, rf_addr_a, rf_wdata);
    end
    ref_mem[5] = 16'hBEEF;
    rr_m = 1'b1;
    @(negedge Clock);
    set_req(0, 1, 0, 6'd5, 6'd0, '0);
    #1;
    tests++;
    if ({r0.ready, rf_we, rf_addr_a, rf_addr_b}
        !== {1'b1, 1'b0, 6'd5, 6'd0}) begin
      fails++;
      $display("FAIL rd_grant got=%b%b a=%0d b=%0d want=10 a=5 b=0",
               r0.ready, rf_we, rf_addr_a, rf_addr_b);
    end
    eb = ref_mem[0];
    @(negedge Clock);
    set_req(0, 0, 0, '0, '0, '0);
    #1;
    tests++;
    if ({r0.rsp_valid, rf_we, rf_addr_a} !== {1'b0, 1'b0, 6'd5}) begin
      fails++;
      $display("FAIL rd_wait got=%b%b a=%0d want=00 a=5",
               r0.rsp_valid, rf_we, rf_addr_a);
    end
    @(negedge Clock);
    #1;
    tests++;
    if ({r0.rsp_valid, r1.rsp_valid, r0.rsp_data_a, r0.rsp_data_b}
        !== {1'b1, 1'b0, 16'hBEEF, eb}) begin
      fails++;
      $display("FAIL rd_resp got=%b%b %h %h want=10 beef %h",
               r0.rsp_valid, r1.rsp_valid,
               r0.rsp_data_a, r0.rsp_data_b, eb);
    end
    r0.rsp_ready = 1'b1;
    @(negedge Clock);
    r0.rsp_ready = 1'b0;
    #1;
    tests++;
    if (r0.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rsp_drop got=%b want=0", r0.rsp_valid);
    end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    bit g;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      a0 = AW'($urandom); a1 = AW'($urandom);
      d0 = DW'($urandom); d1 = DW'($urandom);
      set_req(0, 1, 1, a0, '0, d0);
      set_req(1, 1, 1, a1, '0, d1);
      #1;
      g = (i % 2) == 1;
      tests++;
      if ({r0.ready, r1.ready, rf_we, rf_addr_a, rf_wdata}
          !== {!g, g, 1'b1, g ? a1 : a0, g ? d1 : d0}) begin
        fails++;
        $display("FAIL alt_grant%0d got=%b%b%b a=%0d d=%h want_g=%0d",
                 i, r0.ready, r1.ready, rf_we, rf_addr_a,
                 rf_wdata, g);
      end
      if (g) ref_mem[a1] = d1;
      else   ref_mem[a0] = d0;
      rr_m = !g;
    end
    @(negedge Clock);
    idle_all();
  endtask

  task automatic test_hold();
    logic [AW-1:0] a, b;
    logic [DW-1:0] ea, eb;
    a = AW'($urandom);
    b = AW'($urandom);
    @(negedge Clock);
    set_req(1, 1, 0, a, b, '0);
    #1;
    tests++;
    if ({r0.ready, r1.ready} !== 2'b01) begin
      fails++;
      $display("FAIL hold_grant got=%b%b want=01",
               r0.ready, r1.ready);
    end
    ea = ref_mem[a];
    eb = ref_mem[b];
    rr_m = 1'b0;
    @(negedge Clock);
    set_req(1, 0, 0, '0, '0, '0);
    set_req(0, 1, 0, AW'($urandom), AW'($urandom), '0);
    #1;
    tests++;
    if (r0.ready !== 1'b0) begin
      fails++;
      $display("FAIL hold_wait_rdy got=%b want=0", r0.ready);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      #1;
      tests++;
      if ({r1.rsp_valid, r0.rsp_valid, r0.ready, r1.rsp_data_a,
           r1.rsp_data_b} !== {3'b100, ea, eb}) begin
        fails++;
        $display("FAIL hold_cyc%0d got=%b%b%b %h %h want=100 %h %h",
                 k, r1.rsp_valid, r0.rsp_valid, r0.ready,
                 r1.rsp_data_a, r1.rsp_data_b, ea, eb);
      end
      if (k == 9) begin
        r1.rsp_ready = 1'b1;
        r0.valid = 1'b0;
      end
    end
    @(negedge Clock);
    r1.rsp_ready = 1'b0;
    #1;
    tests++;
    if (r1.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release got=%b want=0", r1.rsp_valid);
    end
  endtask

  task automatic test_same_cycle();
    logic [AW-1:0] a, b;
    logic [DW-1:0] d, eb;
    a = AW'($urandom_range(0, 62));
    b = AW'($urandom);
    d = DW'($urandom);
    @(negedge Clock);
    set_req(0, 1, 1, a, '0, d);
    #1;
    tests++;
    if (r0.ready !== 1'b1) begin
      fails++;
      $display("FAIL same_pre got=%b want=1", r0.ready);
    end
    ref_mem[a] = d;
    rr_m = 1'b1;
    @(negedge Clock);
    set_req(1, 1, 1, 6'd63, '0, 16'h1234);
    set_req(0, 1, 0, 6'd63, b, '0);
    #1;
    tests++;
    if ({r0.ready, r1.ready, rf_we, rf_addr_a, rf_wdata}
        !== {2'b01, 1'b1, 6'd63, 16'h1234}) begin
      fails++;
      $display("FAIL same_wr got=%b%b%b a=%0d d=%h want=011 a=63 d=1234",
               r0.ready, r1.ready, rf_we, rf_addr_a, rf_wdata);
    end
    ref_mem[63] = 16'h1234;
    rr_m = 1'b0;
    @(negedge Clock);
    set_req(1, 0, 0, '0, '0, '0);
    #1;
    tests++;
    if ({r0.ready, rf_we, rf_addr_a} !== {2'b10, 6'd63}) begin
      fails++;
      $display("FAIL same_rd got=%b%b a=%0d want=10 a=63",
               r0.ready, rf_we, rf_addr_a);
    end
    eb = ref_mem[b];
    rr_m = 1'b1;
    @(negedge Clock);
    set_req(0, 0, 0, '0, '0, '0);
    @(negedge Clock);
    #1;
    tests++;
    if ({r0.rsp_valid, r0.rsp_data_a, r0.rsp_data_b}
        !== {1'b1, 16'h1234, eb}) begin
      fails++;
      $display("FAIL same_resp got=%b %h %h want=1 1234 %h",
               r0.rsp_valid, r0.rsp_data_a, r0.rsp_data_b, eb);
    end
    r0.rsp_ready = 1'b1;
    @(negedge Clock);
    r0.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge Clock);
    set_req(0, 1, 0, AW'($urandom), AW'($urandom), '0);
    #1;
    tests++;
    if (r0.ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_grant got=%b want=1", r0.ready);
    end
    @(negedge Clock);
    set_req(0, 0, 0, '0, '0, '0);
    @(negedge Clock);
    #1;
    tests++;
    if (r0.rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rmid_hold got=%b want=1", r0.rsp_valid);
    end
    set_req(0, 1, 1, 6'd9, '0, 16'hAAAA);
    set_req(1, 1, 1, 6'd10, '0, 16'hBBBB);
    nReset = 1'b0;
    #1;
    tests++;
    if (all_outs() !== '0) begin
      fails++;
      $display("FAIL rmid_outputs got=%h want=0", all_outs());
    end
    @(negedge Clock);
    idle_all();
    nReset = 1'b1;
    rr_m = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      #1;
      tests++;
      if ({r0.rsp_valid, r1.rsp_valid, rf_we} !== 3'b000) begin
        fails++;
        $display("FAIL rmid_after%0d got=%b%b%b want=000", k,
                 r0.rsp_valid, r1.rsp_valid, rf_we);
      end
    end
  endtask

  task automatic test_random();
    bit            hv [2];
    bit            hw [2];
    logic [AW-1:0] ha [2];
    logic [AW-1:0] hb [2];
    logic [DW-1:0] hd [2];
    bit            pend = 1'b0;
    int            age = 0;
    bit            own = 1'b0;
    logic [DW-1:0] ea = '0, eb = '0;
    int            reads = 0, grants = 0;
    int            dut_req_hs = 0, dut_rsp_hs = 0;
    bit            any, g, take;
    logic [1:0]    er, ev;
    logic [2*DW-1:0] od;
    for (int j = 0; j < 2; j++) hv[j] = 1'b0;
    for (int c = 0; c < 640; c++) begin
      @(negedge Clock);
      for (int j = 0; j < 2; j++) begin
        if (!hv[j] && c < 600 && $urandom_range(0, 2) != 0) begin
          hv[j] = 1'b1;
          hw[j] = $urandom_range(0, 1) == 1;
          ha[j] = $urandom_range(0, 1) == 1 ?
                  AW'($urandom_range(0, 7)) : AW'($urandom);
          hb[j] = AW'($urandom_range(0, 7));
          hd[j] = DW'($urandom);
        end
        set_req(j, hv[j], hw[j], ha[j], hb[j], hd[j]);
      end
      r0.rsp_ready = c >= 600 || $urandom_range(0, 1) == 1;
      r1.rsp_ready = c >= 600 || $urandom_range(0, 1) == 1;
      #1;
      any = !pend && (hv[0] || hv[1]);
      g   = (hv[0] && hv[1]) ? rr_m : hv[1];
      er  = any ? (g ? 2'b01 : 2'b10) : 2'b00;
      ev  = (pend && age >= 2) ? (own ? 2'b01 : 2'b10) : 2'b00;
      tests++;
      if ({r0.ready, r1.ready, r0.rsp_valid, r1.rsp_valid,
           rf_we} !== {er, ev, any && hw[g]}) begin
        fails++;
        $display("FAIL rnd_ctl c=%0d got=%b%b%b%b%b want=%b%b%b",
                 c, r0.ready, r1.ready, r0.rsp_valid,
                 r1.rsp_valid, rf_we, er, ev, any && hw[g]);
      end
      if (ev != 2'b00) begin
        od = own ? {r1.rsp_data_a, r1.rsp_data_b}
                 : {r0.rsp_data_a, r0.rsp_data_b};
        tests++;
        if (od !== {ea, eb}) begin
          fails++;
          $display("FAIL rnd_data c=%0d own=%0d got=%h want=%h",
                   c, own, od, {ea, eb});
        end
      end
      if (r0.valid && r0.ready) dut_req_hs++;
      if (r1.valid && r1.ready) dut_req_hs++;
      if (r0.rsp_valid && r0.rsp_ready) dut_rsp_hs++;
      if (r1.rsp_valid && r1.rsp_ready) dut_rsp_hs++;
      if (pend) begin
        take = own ? r1.rsp_ready : r0.rsp_ready;
        if (age >= 2 && take) pend = 1'b0;
        else age++;
      end
      if (any) begin
        grants++;
        rr_m = !g;
        if (hw[g]) begin
          ref_mem[ha[g]] = hd[g];
        end else begin
          pend = 1'b1;
          age  = 1;
          own  = g;
          ea   = ref_mem[ha[g]];
          eb   = ref_mem[hb[g]];
          reads++;
        end
        hv[g] = 1'b0;
      end
    end
    idle_all();
    tests++;
    if ({dut_req_hs, dut_rsp_hs, 1'(pend)}
        !== {grants, reads, 1'b0}) begin
      fails++;
      $display("FAIL rnd_counts got req=%0d rsp=%0d want req=%0d rsp=%0d pend=%0d",
               dut_req_hs, dut_rsp_hs, grants, reads, pend);
    end
  endtask

  initial begin
    logic [DW-1:0] t;
    for (int i = 0; i < 64; i++) begin
      t = DW'($urandom);
      rf_mem[i] <= t;
      ref_mem[i] = t;
    end
    idle_all();
    test_reset();
    test_write_read();
    test_alternate();
    test_hold();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
